msg_mailbox: RTL

Hardware typed-message mailbox for the AXI4-Lite verification environment: NUM_CH producer channels each push tagged messages (type code plus payload) into a per-channel FIFO, and a round-robin arbiter drains them through one registered output port to the consumer. It is the parametrised, synthesizable successor of the testbench message-type definitions, using the same type encoding. It also adds the following:
- per-channel buffering;
- filtering of undefined messages;
- tracking of checker completion.

---
 rtl/msg_mailbox.sv | 173 +++++++++++++++++
 1 files changed

// File: rtl/msg_mailbox.sv
// Typed-message mailbox: per-channel FIFOs feeding one registered output through a
// round-robin arbiter; undefined message types are consumed, counted and discarded.
module msg_mailbox #(
   parameter int NUM_CH = 2,
   parameter int DEPTH  = 4,
   parameter int DATA_W = 32,
   parameter int TYPE_W = 3,
   localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
   input  logic                     ACLK,
   input  logic                     ARESETN,
   input  logic [NUM_CH-1:0]        in_valid,
   output logic [NUM_CH-1:0]        in_ready,
   input  logic [NUM_CH*TYPE_W-1:0] in_type,
   input  logic [NUM_CH*DATA_W-1:0] in_data,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [TYPE_W-1:0]        out_type,
   output logic [DATA_W-1:0]        out_data,
   output logic [CH_W-1:0]          out_ch,
   output logic [7:0]               drop_cnt,
   output logic                     err_undef,
   output logic                     all_done
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [TYPE_W-1:0] T_DONE = TYPE_W'(5);
   localparam logic [TYPE_W-1:0] T_MAX  = TYPE_W'(5);

   logic [TYPE_W-1:0] mem_type_q [NUM_CH][DEPTH];
   logic [DATA_W-1:0] mem_data_q [NUM_CH][DEPTH];
   logic [AW:0]       wr_ptr_q [NUM_CH];
   logic [AW:0]       wr_ptr_d [NUM_CH];
   logic [AW:0]       rd_ptr_q [NUM_CH];
   logic [AW:0]       rd_ptr_d [NUM_CH];

   logic [NUM_CH-1:0] full, empty, store, drop, pop;
   logic [CH_W-1:0]   last_grant_q, last_grant_d, gnt, cand;
   logic              gnt_found, load;

   logic              out_valid_q, out_valid_d;
   logic [TYPE_W-1:0] out_type_q, out_type_d;
   logic [DATA_W-1:0] out_data_q, out_data_d;
   logic [CH_W-1:0]   out_ch_q, out_ch_d;
   logic [7:0]        drop_cnt_q, drop_cnt_d;
   logic              err_undef_q, err_undef_d;
   logic [NUM_CH-1:0] done_seen_q, done_seen_d;
   logic [3:0]        n_drop;
   logic [8:0]        drop_sum;

   function automatic logic is_defined(input logic [TYPE_W-1:0] t);
      return (t != '0) && (t <= T_MAX);
   endfunction

   // NOTE: every signal written in always_comb gets a default first, so no latch is inferred.
   always_comb begin
      full   = '0;
      empty  = '0;
      store  = '0;
      drop   = '0;
      n_drop = '0;
      for (int c = 0; c < NUM_CH; c++) begin
         full[c]  = (wr_ptr_q[c][AW-1:0] == rd_ptr_q[c][AW-1:0]) &&
                    (wr_ptr_q[c][AW] != rd_ptr_q[c][AW]);
         empty[c] = (wr_ptr_q[c] == rd_ptr_q[c]);
         // Handshake depends only on !full; undefined types complete it but are not stored.
         store[c] = in_valid[c] && !full[c] &&  is_defined(in_type[c*TYPE_W +: TYPE_W]);
         drop[c]  = in_valid[c] && !full[c] && !is_defined(in_type[c*TYPE_W +: TYPE_W]);
         n_drop   = n_drop + 4'(drop[c]);
      end
   end

   assign in_ready = ~full;

   // Round-robin search starting one past the last granted channel.
   always_comb begin
      gnt       = last_grant_q;
      cand      = '0;
      gnt_found = 1'b0;
      for (int i = 1; i <= NUM_CH; i++) begin
         cand = CH_W'((int'(last_grant_q) + i) % NUM_CH);
         if (!gnt_found && !empty[cand]) begin
            gnt_found = 1'b1;
            gnt       = cand;
         end
      end
   end

   always_comb begin
      load         = !out_valid_q || out_ready;
      pop          = '0;
      out_valid_d  = out_valid_q;
      out_type_d   = out_type_q;
      out_data_d   = out_data_q;
      out_ch_d     = out_ch_q;
      last_grant_d = last_grant_q;
      if (load) begin
         if (gnt_found) begin
            pop[gnt]     = 1'b1;
            out_valid_d  = 1'b1;
            out_type_d   = mem_type_q[gnt][rd_ptr_q[gnt][AW-1:0]];
            out_data_d   = mem_data_q[gnt][rd_ptr_q[gnt][AW-1:0]];
            out_ch_d     = gnt;
            last_grant_d = gnt;
         end else begin
            out_valid_d  = 1'b0;
         end
      end

      for (int c = 0; c < NUM_CH; c++) begin
         wr_ptr_d[c] = wr_ptr_q[c] + (AW+1)'(store[c]);
         rd_ptr_d[c] = rd_ptr_q[c] + (AW+1)'(pop[c]);
      end

      drop_sum    = {1'b0, drop_cnt_q} + 9'(n_drop);
      drop_cnt_d  = drop_sum[8] ? 8'hFF : drop_sum[7:0];
      err_undef_d = err_undef_q | (|drop);

      done_seen_d = done_seen_q;
      if (out_valid_q && out_ready && (out_type_q == T_DONE))
         done_seen_d[out_ch_q] = 1'b1;
   end

   // NOTE: sequential state uses non-blocking assignments so all flops update together.
   always_ff @(posedge ACLK or negedge ARESETN) begin
      if (!ARESETN) begin
         for (int c = 0; c < NUM_CH; c++) begin
            wr_ptr_q[c] <= '0;
            rd_ptr_q[c] <= '0;
         end
         last_grant_q <= CH_W'(NUM_CH - 1);
         out_valid_q  <= 1'b0;
         out_type_q   <= '0;
         out_data_q   <= '0;
         out_ch_q     <= '0;
         drop_cnt_q   <= '0;
         err_undef_q  <= 1'b0;
         done_seen_q  <= '0;
      end else begin
         for (int c = 0; c < NUM_CH; c++) begin
            wr_ptr_q[c] <= wr_ptr_d[c];
            rd_ptr_q[c] <= rd_ptr_d[c];
         end
         last_grant_q <= last_grant_d;
         out_valid_q  <= out_valid_d;
         out_type_q   <= out_type_d;
         out_data_q   <= out_data_d;
         out_ch_q     <= out_ch_d;
         drop_cnt_q   <= drop_cnt_d;
         err_undef_q  <= err_undef_d;
         done_seen_q  <= done_seen_d;
      end
   end

   // NOTE: the storage array is not reset; the pointers alone define which entries are valid.
   always_ff @(posedge ACLK) begin
      for (int c = 0; c < NUM_CH; c++) begin
         if (store[c]) begin
            mem_type_q[c][wr_ptr_q[c][AW-1:0]] <= in_type[c*TYPE_W +: TYPE_W];
            mem_data_q[c][wr_ptr_q[c][AW-1:0]] <= in_data[c*DATA_W +: DATA_W];
         end
      end
   end

   assign out_valid = out_valid_q;
   assign out_type  = out_type_q;
   assign out_data  = out_data_q;
   assign out_ch    = out_ch_q;
   assign drop_cnt  = drop_cnt_q;
   assign err_undef = err_undef_q;
   assign all_done  = &done_seen_q;

endmodule
